// File: rtl/mux_arbiter4.sv
// ---------------------------------------------------------------------------
// mux_arbiter4
// Round-robin arbiter that hands one shared 4-input datapath mux (and the
// resource behind it) to one of four requesters at a time. A tenure lasts
// until the owner drops its request, or until MAX_BEATS beats have been
// accepted (MAX_BEATS = 0 disables the forced release).
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset_n    asynchronous active-low reset
//   req[3:0]   request per requester, held for the whole transaction
//   rsc_ready  shared resource accepts a beat this cycle
//   gnt[3:0]   registered one-hot grant, 0 while idle
//   sel[1:0]   registered mux select, index of current or last owner
//   xfer       beat accepted this cycle (combinational)
//   busy       registered, high while a tenure is active
// ---------------------------------------------------------------------------
module mux_arbiter4 #(
    parameter int MAX_BEATS = 8,
    parameter int BEAT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       rsc_ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       xfer,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [BEAT_W-1:0] BEAT_SAT = {BEAT_W{1'b1}};

    state_t            state_reg, state_next;
    logic [1:0]        owner_reg, owner_next;
    logic [1:0]        ptr_reg,   ptr_next;
    logic [BEAT_W-1:0] beat_reg,  beat_next;
    logic [3:0]        gnt_reg,   gnt_next;
    logic [1:0]        sel_reg,   sel_next;
    logic              busy_reg,  busy_next;

    // Requests rotated so that bit 0 is the requester the pointer names;
    // the lowest set bit of this vector is then the round-robin winner.
    logic [3:0] rot_req;
    logic [1:0] offset;
    logic [1:0] choice;
    logic       last_beat;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rotate
        assign rot_req[gi] = req[ptr_reg + 2'(gi)];
    end

    always_comb begin
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = 2'(k);
            end
        end
    end

    assign choice = ptr_reg + offset;

    // Accepting a beat requires the owner to still be requesting, so a req
    // drop in the final-beat cycle suppresses both the beat and last_beat.
    assign xfer = (state_reg == GRANT) && req[owner_reg] && rsc_ready;

    if (MAX_BEATS == 0) begin : g_unlimited
        assign last_beat = 1'b0;
    end else begin : g_limited
        localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
        assign last_beat = xfer && (beat_reg == LAST_BEAT);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            owner_reg <= 2'd0;
            ptr_reg   <= 2'd0;
            beat_reg  <= '0;
            gnt_reg   <= 4'b0000;
            sel_reg   <= 2'd0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            beat_reg  <= beat_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        beat_next  = beat_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    owner_next = choice;
                    ptr_next   = choice + 2'd1;
                    beat_next  = '0;
                    gnt_next   = 4'(1) << choice;
                    sel_next   = choice;
                    busy_next  = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_reg] || last_beat) begin
                    // sel is left alone so the mux keeps pointing at the
                    // last owner while idle.
                    state_next = IDLE;
                    gnt_next   = 4'b0000;
                    busy_next  = 1'b0;
                end else if (xfer && (beat_reg != BEAT_SAT)) begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        gnt  = gnt_reg;
        sel  = sel_reg;
        busy = busy_reg;
    end

endmodule
